// File: rtl/s1_serial_xcvr.sv
// rtl/s1_serial_xcvr.sv - S1 serial link node: uploads RB1 as transposed 18-bit frames, downloads byte frames into RB1
module s1_serial_xcvr (
    input  logic       clk,
    input  logic       rst,
    input  logic       updown,
    output logic       S1_done,
    output logic       RB1_RW,
    output logic [4:0] RB1_A,
    output logic [7:0] RB1_D,
    input  logic [7:0] RB1_Q,
    inout  wire        sen,
    inout  wire        sd
);

    typedef enum logic [2:0] {
        UP_ADDR, UP_DATA, UP_GAP, UP_IDLE, DN_WAIT, DN_SHIFT, DN_WRITE, DONE
    } state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [2:0]  frame_n;
    logic [4:0]  wr_cnt;
    logic [11:0] sr;
    logic        sen_q, sd_q;
    logic        abort;
    logic [1:0]  abit;

    assign sen   = updown ? 1'bz : sen_q;
    assign sd    = updown ? 1'bz : sd_q;
    assign abort = updown && (state == UP_ADDR || state == UP_DATA ||
                              state == UP_GAP  || state == UP_IDLE);
    assign abit  = 2'd2 - cnt[1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= UP_ADDR;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) begin
            state_nx = DN_WAIT;
        end else begin
            case (state)
                UP_ADDR:  if (cnt == 5'd2) state_nx = UP_DATA;
                UP_DATA:  if (cnt == 5'd17) state_nx = UP_GAP;
                UP_GAP:   state_nx = (frame_n == 3'd7) ? UP_IDLE : UP_ADDR;
                UP_IDLE:  state_nx = UP_IDLE;
                DN_WAIT:  if (updown && !sen) state_nx = DN_SHIFT;
                DN_SHIFT: begin
                    if (sen)               state_nx = DN_WAIT;
                    else if (cnt == 5'd12) state_nx = DN_WRITE;
                end
                DN_WRITE: state_nx = (wr_cnt < 5'd18) ? DN_WAIT : DONE;
                default:  state_nx = DONE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            frame_n <= '0;
            wr_cnt  <= '0;
            sr      <= '0;
            sen_q   <= 1'b1;
            sd_q    <= 1'b0;
            RB1_RW  <= 1'b1;
            RB1_A   <= '0;
            RB1_D   <= '0;
            S1_done <= 1'b0;
        end else begin
            RB1_RW <= 1'b1;
            if (abort) begin
                sen_q <= 1'b1;
                sd_q  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    UP_ADDR: begin
                        // Address 0 is presented early so its read data lands on the first data bit
                        sen_q <= 1'b0;
                        sd_q  <= frame_n[abit];
                        RB1_A <= (cnt == 5'd2) ? 5'd1 : 5'd0;
                        cnt   <= (cnt == 5'd2) ? 5'd0 : cnt + 5'd1;
                    end
                    UP_DATA: begin
                        sen_q <= 1'b0;
                        sd_q  <= RB1_Q[~frame_n];
                        if (cnt < 5'd16) RB1_A <= cnt + 5'd2;
                        cnt   <= (cnt == 5'd17) ? 5'd0 : cnt + 5'd1;
                    end
                    UP_GAP: begin
                        sen_q   <= 1'b1;
                        sd_q    <= 1'b0;
                        RB1_A   <= '0;
                        cnt     <= '0;
                        frame_n <= frame_n + 3'd1;
                    end
                    UP_IDLE: begin
                        sen_q <= 1'b1;
                        sd_q  <= 1'b0;
                    end
                    DN_WAIT: begin
                        sen_q <= 1'b1;
                        sd_q  <= 1'b0;
                        if (updown && !sen) begin
                            sr  <= {sr[10:0], sd};
                            cnt <= 5'd1;
                        end
                    end
                    DN_SHIFT: begin
                        if (sen) begin
                            cnt <= '0;
                        end else if (cnt == 5'd12) begin
                            RB1_RW <= 1'b0;
                            RB1_A  <= sr[11:7];
                            RB1_D  <= {sr[6:0], sd};
                            wr_cnt <= wr_cnt + 5'd1;
                            cnt    <= '0;
                        end else begin
                            sr  <= {sr[10:0], sd};
                            cnt <= cnt + 5'd1;
                        end
                    end
                    DN_WRITE: if (wr_cnt >= 5'd18) S1_done <= 1'b1;
                    default:  S1_done <= 1'b1;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_s1_serial_xcvr.sv
// tb/tb_s1_serial_xcvr.sv - scoreboard bench for s1_serial_xcvr upload/download
module tb_s1_serial_xcvr;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       updown = 1'b0;
    logic       S1_done, RB1_RW;
    logic [4:0] RB1_A;
    logic [7:0] RB1_D, RB1_Q;
    logic       tb_sen = 1'b1, tb_sd = 1'b0;
    logic       load = 1'b0;
    wire        sen, sd;

    logic [7:0]  img [0:31];
    logic [7:0]  mem [0:31];
    logic [20:0] up_q [$];
    logic [12:0] wr_q [$];
    logic [20:0] sh;
    int          nbits = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    assign sen = updown ? tb_sen : 1'bz;
    assign sd  = updown ? tb_sd  : 1'bz;

    s1_serial_xcvr dut (
        .clk(clk), .rst(rst), .updown(updown), .S1_done(S1_done),
        .RB1_RW(RB1_RW), .RB1_A(RB1_A), .RB1_D(RB1_D), .RB1_Q(RB1_Q),
        .sen(sen), .sd(sd)
    );

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 32; i++) mem[i] <= img[i];
        end else if (!RB1_RW) begin
            mem[RB1_A] <= RB1_D;
        end else begin
            RB1_Q <= mem[RB1_A];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            nbits = 0;
        end else if (!updown) begin
            if (sen == 1'b0) begin
                sh = {sh[19:0], sd};
                nbits++;
            end else if (nbits > 0) begin
                if (nbits != 21)          check("frame_len", nbits, 21);
                else if (up_q.size() == 0) check("unexpected_frame", 0, 1);
                else                      check("frame", {11'b0, sh}, {11'b0, up_q.pop_front()});
                nbits = 0;
            end
        end
        if (rst && RB1_RW == 1'b0) begin
            if (wr_q.size() == 0) check("unexpected_write", {19'b0, RB1_A, RB1_D}, 32'hFFFF_FFFF);
            else                  check("write", {19'b0, RB1_A, RB1_D}, {19'b0, wr_q.pop_front()});
        end
    end

    task automatic push_frames();
        logic [17:0] d;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 18; i++) d[17-i] = img[i][7-n];
            up_q.push_back({n[2:0], d});
        end
    endtask

    task automatic hold_reset(input logic mode);
        rst    = 1'b0;
        updown = mode;
        tb_sen = 1'b1;
        tb_sd  = 1'b0;
        #1;
        up_q.delete();
        wr_q.delete();
        load = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        load = 1'b0;
        if (!mode) check("rst_sen", {31'b0, sen}, 1);
        check("rst_rw", {31'b0, RB1_RW}, 1);
        check("rst_done", {31'b0, S1_done}, 0);
        check("rst_a", {27'b0, RB1_A}, 0);
        check("rst_d", {24'b0, RB1_D}, 0);
    endtask

    task automatic start_upload();
        hold_reset(1'b0);
        push_frames();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_upload();
        for (int c = 0; c < 400 && (up_q.size() != 0 || nbits != 0); c++) @(posedge clk);
        check("up_pending", up_q.size(), 0);
        repeat (5) @(negedge clk);
        check("idle_sen", {31'b0, sen}, 1);
    endtask

    task automatic send(input logic [12:0] w, input int nb);
        for (int b = 0; b < nb; b++) begin
            @(posedge clk);
            #1;
            tb_sen = 1'b0;
            tb_sd  = w[12-b];
        end
        @(posedge clk);
        #1;
        tb_sen = 1'b1;
        tb_sd  = 1'b0;
    endtask

    task automatic start_download();
        hold_reset(1'b1);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        img[0] = 8'h80;
        start_upload();
        wait_upload();

        img[0]  = 8'h00;
        img[17] = 8'h01;
        start_upload();
        wait_upload();

        for (int i = 0; i < 18; i++) img[i] = 8'hFF;
        start_upload();
        wait_upload();

        for (int i = 0; i < 18; i++) img[i] = 8'($urandom_range(0, 255));
        start_upload();
        wait_upload();

        start_upload();
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_sen", {31'b0, sen}, 1);
        check("midrst_rw", {31'b0, RB1_RW}, 1);
        check("midrst_done", {31'b0, S1_done}, 0);
        start_upload();
        wait_upload();

        for (int i = 0; i < 32; i++) img[i] = 8'h00;
        start_download();
        wr_q.push_back({5'd3, 8'hA5});
        send({5'd3, 8'hA5}, 13);
        repeat (3) @(posedge clk);
        #1;
        check("dn1_pending", wr_q.size(), 0);
        check("dn1_done", {31'b0, S1_done}, 0);
        check("dn1_mem", {24'b0, mem[3]}, 32'hA5);

        start_download();
        send(13'h1FFF, 5);
        for (int a = 0; a < 18; a++) begin
            wr_q.push_back({a[4:0], a[7:0] ^ 8'h5A});
            send({a[4:0], a[7:0] ^ 8'h5A}, 13);
            if (a == 16) check("done_early", {31'b0, S1_done}, 0);
        end
        check("done_on_pulse", {31'b0, S1_done}, 0);
        @(posedge clk);
        #1;
        check("done_after", {31'b0, S1_done}, 1);
        repeat (10) @(posedge clk);
        #1;
        check("done_hold", {31'b0, S1_done}, 1);
        check("dn_pending", wr_q.size(), 0);
        for (int a = 0; a < 18; a++) check("dn_mem", {24'b0, mem[a]}, {24'b0, a[7:0] ^ 8'h5A});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
